// File: rtl/chanbond_monitor_mlane.sv
// chanbond_monitor_mlane
// Multi-lane channel-bonding watchdog. It waits for comma alignment on every
// lane and then times the channel-bond search. When the search times out it
// pulses RXRESET and tries again, counting the consecutive retries.
// Optional feature macro: CHANBOND_RETRY_LIMIT_EN. When it is defined, the
// block declares a hard failure (CB_FAIL) once MAX_RETRIES pulses have been
// spent without bonding.
//
// state     | meaning
// S_IDLE    | no bonding request outstanding
// S_WAIT    | bonding requested, waiting for all lanes to comma-align
// S_SEARCH  | all lanes aligned, timing the channel-bond search
// S_RESET   | RXRESET pulse in progress (RESET_CYCLES cycles)
// S_FAILED  | retry limit exhausted, held until the request drops
module chanbond_monitor_mlane #(
    parameter int NUM_LANES    = 4,
    parameter int TIMEOUT      = 128,
    parameter int CNT_W        = 8,
    parameter int RESET_CYCLES = 4,
    parameter int RETRY_W      = 4,
    parameter int MAX_RETRIES  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_LANES-1:0] COMMA_ALIGN_DONE,
    input  logic                 CORE_ENCHANSYNC,
    input  logic                 CHANBOND_DONE,
    output logic                 RXRESET,
    output logic [RETRY_W-1:0]   RETRY_CNT,
    output logic                 CB_FAIL
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_SEARCH = 3'd2,
        S_RESET  = 3'd3,
        S_FAILED = 3'd4
    } state_t;

`ifdef CHANBOND_RETRY_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [RC_W-1:0]    RC_LAST   = RC_W'(RESET_CYCLES - 1);
    localparam logic [RETRY_W-1:0] MAX_R     = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_SAT = {RETRY_W{1'b1}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [RC_W-1:0]    rcnt_q, rcnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               rxreset_q, rxreset_d;
    logic               fail_q, fail_d;
    logic               all_align;

    assign all_align = &COMMA_ALIGN_DONE;

    // Next-state, timers and retry count; both timers idle at zero so each
    // entry into SEARCH or RESET starts a fresh count.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        timer_d = '0;
        rcnt_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (CORE_ENCHANSYNC && !CHANBOND_DONE) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!CORE_ENCHANSYNC) state_d = S_IDLE;
                else if (all_align)   state_d = S_SEARCH;
            end
            S_SEARCH: begin
                if (!CORE_ENCHANSYNC) begin
                    state_d = S_IDLE;
                end else if (!all_align) begin
                    state_d = S_WAIT;
                end else if (CHANBOND_DONE) begin
                    // success wins over a coincident timeout
                    state_d = S_IDLE;
                    retry_d = '0;
                end else if (timer_q == TO_LAST) begin
                    if (LIMIT_EN && (retry_q == MAX_R)) begin
                        state_d = S_FAILED;
                    end else begin
                        state_d = S_RESET;
                        if (retry_q != RETRY_SAT) retry_d = retry_q + RETRY_W'(1);
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            S_RESET: begin
                if (rcnt_q == RC_LAST) state_d = S_WAIT;
                else                   rcnt_d  = rcnt_q + RC_W'(1);
            end
            S_FAILED: begin
                if (!CORE_ENCHANSYNC) begin
                    state_d = S_IDLE;
                    retry_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        rxreset_d = (state_d == S_RESET);
        fail_d    = LIMIT_EN && (state_d == S_FAILED);
    end

    // State and registered outputs, cleared asynchronously by RST.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            rcnt_q    <= '0;
            retry_q   <= '0;
            rxreset_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            rcnt_q    <= rcnt_d;
            retry_q   <= retry_d;
            rxreset_q <= rxreset_d;
            fail_q    <= fail_d;
        end
    end

    assign RXRESET   = rxreset_q;
    assign RETRY_CNT = retry_q;
    assign CB_FAIL   = fail_q;

endmodule
